// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned OFFSET_W       = 2;
  localparam int unsigned UNCACHED_BIT   = 31;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned STRB_W         = DATA_W / 8;
  localparam int unsigned LINE_LSB       = OFFSET_W + 2;

  // Overlay the enabled bytes of new_w onto old_w.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the data cache: asynchronous read, byte-strobed
// word write and whole-line valid/tag write. Only the valid bits are reset.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 64,
  localparam int unsigned IDX_W = $clog2(LINES),
  localparam int unsigned TAG_W = ADDR_W - LINE_LSB - IDX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    i_rd_idx,
  input  logic [OFFSET_W-1:0] i_rd_off,
  output logic                o_rd_valid,
  output logic [TAG_W-1:0]    o_rd_tag,
  output logic [DATA_W-1:0]   o_rd_data,
  input  logic                i_wr_en,
  input  logic [IDX_W-1:0]    i_wr_idx,
  input  logic [OFFSET_W-1:0] i_wr_off,
  input  logic [DATA_W-1:0]   i_wr_data,
  input  logic [STRB_W-1:0]   i_wr_strb,
  input  logic                i_line_en,
  input  logic [IDX_W-1:0]    i_line_idx,
  input  logic [TAG_W-1:0]    i_line_tag
);

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES][WORDS_PER_LINE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_line_en) begin
      r_valid[i_line_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_line_en) begin
      r_tag[i_line_idx] <= i_line_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[i_wr_idx][i_wr_off] <= merge_bytes(r_data[i_wr_idx][i_wr_off], i_wr_data, i_wr_strb);
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx][i_rd_off];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Define DCACHE_UNCACHED_EN to treat addr[31]=1 as an uncached region.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 64,
  localparam int unsigned IDX_W = $clog2(LINES),
  localparam int unsigned TAG_W = ADDR_W - LINE_LSB - IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [STRB_W-1:0] core_wstrb,
  output logic [DATA_W-1:0] core_rdata,
  output logic              waiting,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [OFFSET_W-1:0] r_cnt;
  logic [OFFSET_W-1:0] w_cnt_nxt;
  logic [DATA_W-1:0]   r_unc_data;
  logic                w_unc_we;

  logic [IDX_W-1:0]    w_index;
  logic [TAG_W-1:0]    w_tag;
  logic [OFFSET_W-1:0] w_offset;
  logic                w_line_valid;
  logic [TAG_W-1:0]    w_line_tag;
  logic [DATA_W-1:0]   w_rd_data;
  logic                w_uncached;
  logic                w_hit;

  logic                w_wr_en;
  logic [OFFSET_W-1:0] w_wr_off;
  logic [DATA_W-1:0]   w_wr_data;
  logic [STRB_W-1:0]   w_wr_strb;
  logic                w_line_en;
  logic                w_unused;

  assign w_offset = core_addr[LINE_LSB-1:2];
  assign w_index  = core_addr[LINE_LSB +: IDX_W];
  assign w_tag    = core_addr[ADDR_W-1 -: TAG_W];
  assign w_unused = &{1'b0, core_addr[1:0]};

`ifdef DCACHE_UNCACHED_EN
  assign w_uncached = core_addr[UNCACHED_BIT];
`else
  assign w_uncached = 1'b0;
`endif

  // Uncached accesses never hit, so stores to them never touch the array.
  assign w_hit = w_line_valid && (w_line_tag == w_tag) && !w_uncached;

  dcache_array #(.LINES(LINES)) u_array (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (w_index),
    .i_rd_off   (w_offset),
    .o_rd_valid (w_line_valid),
    .o_rd_tag   (w_line_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (w_index),
    .i_wr_off   (w_wr_off),
    .i_wr_data  (w_wr_data),
    .i_wr_strb  (w_wr_strb),
    .i_line_en  (w_line_en),
    .i_line_idx (w_index),
    .i_line_tag (w_tag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_unc_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_unc_we) r_unc_data <= mem_rdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_unc_we    = 1'b0;
    waiting     = 1'b0;
    core_rdata  = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    w_wr_en     = 1'b0;
    w_wr_off    = w_offset;
    w_wr_data   = core_wdata;
    w_wr_strb   = core_wstrb;
    w_line_en   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (core_req) begin
          if (core_we) begin
            waiting     = 1'b1;
            w_state_nxt = S_WRITE;
          end else if (w_hit) begin
            core_rdata = w_rd_data;
          end else begin
            waiting     = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_REFILL;
          end
        end
      end

      // Fill words 0..3 in order; an uncached load takes a single beat.
      S_REFILL: begin
        waiting  = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {core_addr[ADDR_W-1:LINE_LSB], r_cnt, 2'b00};
        if (mem_ack) begin
          if (w_uncached) begin
            w_unc_we    = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_wr_en   = 1'b1;
            w_wr_off  = r_cnt;
            w_wr_data = mem_rdata;
            w_wr_strb = '1;
            w_cnt_nxt = OFFSET_W'(r_cnt + 1'b1);
            if (r_cnt == OFFSET_W'(WORDS_PER_LINE - 1)) begin
              w_line_en   = 1'b1;
              w_state_nxt = S_RESP;
            end
          end
        end
      end

      S_WRITE: begin
        waiting   = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {core_addr[ADDR_W-1:2], 2'b00};
        mem_wdata = core_wdata;
        mem_wstrb = core_wstrb;
        if (mem_ack) begin
          w_wr_en     = w_hit;
          w_state_nxt = S_RESP;
        end
      end

      S_RESP: begin
        if (core_req && !core_we) begin
          core_rdata = w_uncached ? r_unc_data : w_rd_data;
        end
        w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a latency-programmable bus memory model.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_wstrb;
  logic [31:0] core_rdata;
  logic        waiting;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;
  int lat   = 2;
  int wcnt  = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_q [$];
  logic [31:0] wa_q [$];
  logic [31:0] wd_q [$];
  logic [3:0]  ws_q [$];

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_wstrb (core_wstrb),
    .core_rdata (core_rdata),
    .waiting    (waiting),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  // Unwritten locations read back as the inverted address.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  // Bus memory: acks each beat after lat cycles of mem_req.
  always @(negedge clk) begin : bus_model
    logic [31:0] cur;
    mem_ack = 1'b0;
    if (rst || !mem_req) begin
      wcnt = 0;
    end else begin
      wcnt++;
      if (wcnt >= lat) begin
        wcnt    = 0;
        mem_ack = 1'b1;
        if (mem_we) begin
          cur = mem_rd(mem_addr);
          for (int b = 0; b < 4; b++) begin
            if (mem_wstrb[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
          end
          mem[mem_addr] = cur;
          wa_q.push_back(mem_addr);
          wd_q.push_back(mem_wdata);
          ws_q.push_back(mem_wstrb);
        end else begin
          mem_rdata = mem_rd(mem_addr);
          rd_q.push_back(mem_addr);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] data, output int cyc);
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    ws_q.delete();
    @(posedge clk);
    #1;
    core_req   = 1'b1;
    core_we    = we;
    core_addr  = a;
    core_wdata = wd;
    core_wstrb = ws;
    #1;
    cyc = 0;
    while (waiting && cyc < 100) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    if (waiting) chk("wait_bound", 32'(cyc), 32'd0);
    data = core_rdata;
    @(posedge clk);
    #1;
    core_req = 1'b0;
    core_we  = 1'b0;
  endtask

  task automatic chk_reads(input string tag, input logic [31:0] base);
    chk({tag, "_nreads"}, 32'(rd_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rd_q.size()) chk($sformatf("%s_addr%0d", tag, i), rd_q[i], base + 32'(4 * i));
    end
  endtask

  initial begin : stim
    logic [31:0] d;
    int          c;
    int          guard;
    rst        = 1'b1;
    core_req   = 1'b0;
    core_we    = 1'b0;
    core_addr  = '0;
    core_wdata = '0;
    core_wstrb = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    mem[32'h100] = 32'h0000_00A0;
    mem[32'h104] = 32'h0000_00A1;
    mem[32'h108] = 32'h0000_00A2;
    mem[32'h10C] = 32'h0000_00A3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_waiting", 32'(waiting), 32'd0);
    chk("rst_rdata", core_rdata, 32'h0);
    rst = 1'b0;

    // Cold load with two-cycle bus latency.
    access(1'b0, 32'h100, '0, '0, d, c);
    chk("cold_data", d, 32'h0000_00A0);
    chk("cold_cycles", 32'(c), 32'd9);
    chk_reads("cold", 32'h100);

    access(1'b0, 32'h108, '0, '0, d, c);
    chk("hit_data", d, 32'h0000_00A2);
    chk("hit_cycles", 32'(c), 32'd0);
    chk("hit_nreads", 32'(rd_q.size()), 32'd0);

    // Store hit, low halfword.
    access(1'b1, 32'h104, 32'hDEAD_BEEF, 4'b0011, d, c);
    chk("st_cycles", 32'(c), 32'd3);
    chk("st_nwrites", 32'(wa_q.size()), 32'd1);
    chk("st_addr", wa_q[0], 32'h104);
    chk("st_data", wd_q[0], 32'hDEAD_BEEF);
    chk("st_strb", 32'(ws_q[0]), 32'h3);
    access(1'b0, 32'h104, '0, '0, d, c);
    chk("st_merge_lo", d, 32'h0000_BEEF);
    chk("st_merge_lo_cycles", 32'(c), 32'd0);

    // Store hit, high halfword.
    access(1'b1, 32'h10C, 32'h1234_5678, 4'b1100, d, c);
    access(1'b0, 32'h10C, '0, '0, d, c);
    chk("st_merge_hi", d, 32'h1234_00A3);
    chk("st_merge_hi_cycles", 32'(c), 32'd0);

    // Store miss must not allocate.
    access(1'b1, 32'h2000, 32'h5566_7788, 4'b1111, d, c);
    chk("stmiss_nwrites", 32'(wa_q.size()), 32'd1);
    access(1'b0, 32'h2000, '0, '0, d, c);
    chk("stmiss_ld_cycles", 32'(c), 32'd9);
    chk("stmiss_ld_data", d, 32'h5566_7788);
    chk_reads("stmiss", 32'h2000);

    // Same index, different tag: lines evict each other.
    access(1'b0, 32'h40, '0, '0, d, c);
    chk("conf_a_data", d, 32'hFFFF_FFBF);
    chk("conf_a_cycles", 32'(c), 32'd9);
    access(1'b0, 32'h440, '0, '0, d, c);
    chk("conf_b_data", d, 32'hFFFF_FBBF);
    chk("conf_b_cycles", 32'(c), 32'd9);
    access(1'b0, 32'h40, '0, '0, d, c);
    chk("conf_a2_data", d, 32'hFFFF_FFBF);
    chk("conf_a2_cycles", 32'(c), 32'd9);

    // Reset after the second refill beat.
    rd_q.delete();
    @(posedge clk);
    #1;
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = 32'h300;
    guard = 0;
    while (rd_q.size() < 2 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    chk("mid_acks", 32'(rd_q.size()), 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
    chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
    core_req = 1'b0;
    #1;
    chk("mid_rst_waiting", 32'(waiting), 32'd0);
    chk("mid_rst_rdata", core_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    access(1'b0, 32'h300, '0, '0, d, c);
    chk("reload_data", d, 32'hFFFF_FCFF);
    chk("reload_cycles", 32'(c), 32'd9);
    chk_reads("reload", 32'h300);
    access(1'b0, 32'h30C, '0, '0, d, c);
    chk("reload_hit_data", d, 32'hFFFF_FCF3);
    chk("reload_hit_cycles", 32'(c), 32'd0);

    // Reset cleared every valid bit.
    access(1'b0, 32'h100, '0, '0, d, c);
    chk("post_rst_cycles", 32'(c), 32'd9);
    chk("post_rst_data", d, 32'h0000_00A0);

`ifdef DCACHE_UNCACHED_EN
    for (int k = 0; k < 2; k++) begin
      access(1'b0, 32'h8000_0000, '0, '0, d, c);
      chk($sformatf("unc%0d_data", k), d, 32'h7FFF_FFFF);
      chk($sformatf("unc%0d_cycles", k), 32'(c), 32'd3);
      chk($sformatf("unc%0d_nreads", k), 32'(rd_q.size()), 32'd1);
    end
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
